// File: rtl/shift_deser_pkg.sv
// Shared constants for the bit-serial utility blocks (deserializer now, serializer later).
// Holds the alignment state encoding and the bit-counter width helper.
package shift_deser_pkg;

    typedef enum logic {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } deser_state_e;

    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_deser_if.sv
// Serial-in / word-out bundle of the deserializer, including the sticky error flags.
// The slave modport is the deserializer; the master side is the front end plus the consumer.
interface shift_deser_if #(parameter int WIDTH = 8);

    logic             ser_valid;
    logic             ser_data;
    logic             ser_sync;
    logic [WIDTH-1:0] par_data;
    logic             par_valid;
    logic             par_ready;
    logic             overrun;
    logic             sync_err;
    logic             clr_err;

    modport slave (
        input  ser_valid, ser_data, ser_sync, par_ready, clr_err,
        output par_data, par_valid, overrun, sync_err
    );

    modport master (
        output ser_valid, ser_data, ser_sync, par_ready, clr_err,
        input  par_data, par_valid, overrun, sync_err
    );

endinterface

// File: rtl/shift_deser_out_reg.sv
// One-deep valid/ready holding register for completed words.
// A load is taken when the register is empty or draining this cycle; otherwise it is dropped.
module deser_out_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             dropped
);

    logic can_load;

    assign can_load = !valid || ready;
    assign dropped  = load && !can_load;

    always_ff @(posedge clk) begin
        if (rst) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (load && can_load) begin
            data  <= load_data;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer: aligns on ser_sync, assembles WIDTH-bit words and
// hands them to a one-deep output register, flagging overruns and mid-word syncs.
module shift_deser
    import shift_deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic          clk,
    input logic          rst,
    shift_deser_if.slave bus
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    deser_state_e     state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] asm_q, asm_nx;
    logic [WIDTH-1:0] shifted, seed;
    logic             word_done, sync_hit, dropped;
    logic             overrun_q, sync_err_q;

    // seed starts a fresh word from the sync bit, shifted appends to the current one
    generate
        if (MSB_FIRST) begin : g_msb
            assign shifted = {asm_q[WIDTH-2:0], bus.ser_data};
            assign seed    = {{(WIDTH-1){1'b0}}, bus.ser_data};
        end else begin : g_lsb
            assign shifted = {bus.ser_data, asm_q[WIDTH-1:1]};
            assign seed    = {bus.ser_data, {(WIDTH-1){1'b0}}};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= HUNT;
            cnt   <= '0;
            asm_q <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            asm_q <= asm_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        asm_nx    = asm_q;
        word_done = 1'b0;
        sync_hit  = 1'b0;
        if (bus.ser_valid) begin
            if (bus.ser_sync) begin
                // a sync always restarts the word; it is only an error when a word is in flight
                state_nx = ASSEMBLE;
                cnt_nx   = CW'(1);
                asm_nx   = seed;
                sync_hit = (state == ASSEMBLE) && (cnt != '0);
            end else if (state == ASSEMBLE) begin
                asm_nx = shifted;
                if (cnt == LAST) begin
                    cnt_nx    = '0;
                    word_done = 1'b1;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
        end
    end

    deser_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (word_done),
        .load_data (shifted),
        .ready     (bus.par_ready),
        .data      (bus.par_data),
        .valid     (bus.par_valid),
        .dropped   (dropped)
    );

    // a new event wins over a coincident clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            overrun_q  <= dropped  || (overrun_q  && !bus.clr_err);
            sync_err_q <= sync_hit || (sync_err_q && !bus.clr_err);
        end
    end

    assign bus.overrun  = overrun_q;
    assign bus.sync_err = sync_err_q;

endmodule

// File: doc/shift_deser.md
# shift_deser

Serial-to-parallel deserializer: the receive-side counterpart to the util shift register, which delays or serializes a bit stream. It accepts one bit per qualified cycle, aligns to a word-start marker, and assembles `WIDTH`-bit words. Completed words are presented on a one-deep valid/ready output register. It sits at the boundary between bit-serial front ends (SPI-like links, test pattern streams) and word-oriented datapaths.

## Interface
Parameters:
- `WIDTH`, 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, 1: 1 = first received bit lands in `par_data[WIDTH-1]`; 0 = first bit lands in `par_data[0]`.

Ports:
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ser_valid`  in  1  qualifies `ser_data`/`ser_sync` this cycle.
- `ser_data`  in  1  serial bit.
- `ser_sync`  in  1  marks the qualified bit as bit 0 of a new word.
- `par_data`  out  WIDTH  assembled word; stable while `par_valid` and not `par_ready`.
- `par_valid`  out  1  output word available.
- `par_ready`  in  1  consumer accepts the word.
- `overrun`  out  1  sticky: a completed word was dropped because the output was full.
- `sync_err`  out  1  sticky: `ser_sync` arrived mid-word.
- `clr_err`  in  1  clears `overrun` and `sync_err`.

## Operation
- States: HUNT (unaligned) and ASSEMBLE (aligned). Bit counter `cnt` runs 0..WIDTH-1.
- HUNT: qualified bits without `ser_sync` are discarded. A qualified bit with `ser_sync` is stored as bit 0, sets `cnt`=1, and moves to ASSEMBLE.
- ASSEMBLE: each qualified bit is shifted into the assembly register and `cnt` increments.
  - The bit taken at `cnt`=WIDTH-1 completes the word and returns `cnt` to 0.
  - The state stays ASSEMBLE, so back-to-back words need no further sync.
- `ser_sync` at `cnt`=0 in ASSEMBLE: normal, no error.
- `ser_sync` at `cnt`≠0: the partial word is discarded, `sync_err` is set, and the sync bit becomes bit 0 of a new word (`cnt`=1).
- Completion handling:
  - If the output register is empty, or is handshaking (`par_valid && par_ready`) in the same cycle, the word loads and `par_valid`=1.
  - Otherwise the completed word is dropped, `overrun` is set, and the held word is unchanged.
- Handshake: a word transfers when `par_valid && par_ready`. `par_valid` falls next cycle unless a new word loads that same cycle.
- `ser_valid`=0 cycles freeze `cnt`, the state and the assembly register; `ser_data`/`ser_sync` are ignored.
- Error flags: set-priority over `clr_err` when a set and a clear coincide.
- Reset values: state HUNT, `cnt`=0, assembly register 0, `par_data`=0, `par_valid`=0, `overrun`=0, `sync_err`=0. A reset mid-word discards the partial word and any held output word.

## Timing
- Latency: last bit qualified in cycle N → `par_valid`=1 with the word in cycle N+1.
- Sustained throughput: one word per WIDTH qualified cycles, with no bubbles when `par_ready` is held high.
- `par_ready` has no combinational path to any output; `par_valid` does not depend on `par_ready` combinationally.
- Flags rise one cycle after the causing event and clear one cycle after `clr_err`.

## Structure
- State encoding (`HUNT`=0, `ASSEMBLE`=1) and the counter width `$clog2(WIDTH)` go as localparams in the shared util constants include, reused by a future serializer.
- Natural sub-module: `deser_out_reg`, a one-deep valid/ready holding register with accept/drop indication. The bit alignment FSM and counter stay in `shift_deser`.

## Test plan
- Basic, WIDTH=8, MSB_FIRST=1: sync on first bit, stream 1,0,1,0,0,1,0,1, `par_ready`=1 → `par_data`=8'hA5 with `par_valid` one cycle after the 8th bit.
- Continuous stream: 16 bits for 8'h3C then 8'hF0, sync only on the first bit → two words, no gaps, `sync_err`=0.
- Bit order, MSB_FIRST=0: same bit sequence as the basic test → `par_data`=8'hA5 bit-reversed (8'hA5) and for 8'h3C bits → 8'h3C bit-reversed (8'h3C); then stream the bits of 8'h01 MSB-first → 8'h80.
- Backpressure: `par_ready`=0 through two completed words → first word held intact, second word dropped, `overrun`=1. Then `clr_err` → `overrun`=0 next cycle.
- Mid-word sync: sync after 3 bits, then 8 bits of 8'h5A → `sync_err`=1, the partial word is never output, output is 8'h5A.
- Reset and gaps:
  - Assert `rst` after 5 bits → all outputs 0, state HUNT, bits without sync ignored.
  - Random `ser_valid` gaps → same words as the gap-free run.
